// File: rtl/flash_loader_if.sv
// Byte-stream ingress and program-flash write port of the flash loader.
// Latency: n/a (signal bundle only).
// Backpressure: rx_ready from the loader side gates rx_valid/rx_data consumption.
interface flash_loader_if;
   logic        rx_valid;
   logic [7:0]  rx_data;
   logic        rx_ready;
   logic [13:0] flash_addr;
   logic [15:0] flash_data;
   logic        flash_wren;
   logic        core_hold;
   logic        done;
   logic        error;

   // Byte source / status observer side
   modport master (
      output rx_valid, rx_data,
      input  rx_ready, flash_addr, flash_data, flash_wren, core_hold, done, error
   );

   // Loader side
   modport slave (
      input  rx_valid, rx_data,
      output rx_ready, flash_addr, flash_data, flash_wren, core_hold, done, error
   );
endinterface

// File: rtl/flash_loader.sv
// Parses a 0x55/LEN/payload[/CSUM] byte frame and writes 16-bit words into program flash.
// Latency: one byte per cycle, 3 cycles per word (HI, LO, WRITE); flash write strobe one cycle after the LO byte.
// Backpressure: rx_ready deasserts only during the single-cycle WRITE state.
// Option: define FLASH_LOADER_CHECKSUM_EN to require and verify a trailing XOR checksum byte.
module flash_loader (
   input  logic          clk,
   input  logic          rst,
   flash_loader_if.slave bus
);

   localparam logic [7:0] SYNC_BYTE = 8'h55;

   typedef enum logic [3:0] {
      S_IDLE,
      S_LEN_HI,
      S_LEN_LO,
      S_DATA_HI,
      S_DATA_LO,
      S_WRITE,
      S_CSUM,
      S_DONE,
      S_ERR
   } state_t;

`ifdef FLASH_LOADER_CHECKSUM_EN
   // After the payload the frame still carries a checksum byte
   localparam state_t S_PAYLOAD_END = S_CSUM;
`else
   // No checksum byte: the image is complete once the payload is written
   localparam state_t S_PAYLOAD_END = S_DONE;
`endif

   state_t      state, state_nxt;
   logic [13:0] len, len_nxt;
   logic [13:0] addr, addr_nxt;
   logic [15:0] data, data_nxt;
   logic        fire;
`ifdef FLASH_LOADER_CHECKSUM_EN
   logic [7:0]  csum, csum_nxt;
`endif

   assign fire = bus.rx_valid && bus.rx_ready;

   assign bus.flash_addr = addr;
   assign bus.flash_data = data;

   // Status and handshake outputs are pure decodes of the current state
   always_comb begin
      bus.rx_ready   = (state != S_WRITE);
      bus.flash_wren = (state == S_WRITE);
      bus.done       = (state == S_DONE);
      bus.error      = (state == S_ERR);
      // The core runs only when no frame is in progress and the last image is good (or none was attempted)
      bus.core_hold  = !((state == S_IDLE) || (state == S_DONE));
   end

   // Next-state and datapath updates; every register holds unless a byte is consumed or a word is written
   always_comb begin
      state_nxt = state;
      len_nxt   = len;
      addr_nxt  = addr;
      data_nxt  = data;
`ifdef FLASH_LOADER_CHECKSUM_EN
      csum_nxt  = csum;
`endif
      case (state)
         S_IDLE, S_DONE, S_ERR: begin
            // Only a sync byte starts a frame; anything else is line noise
            if (fire && (bus.rx_data == SYNC_BYTE)) begin
               state_nxt = S_LEN_HI;
`ifdef FLASH_LOADER_CHECKSUM_EN
               csum_nxt  = '0;
`endif
            end
         end
         S_LEN_HI: begin
            if (fire) begin
               // Lengths beyond the 14-bit word address space cannot be honoured
               if (bus.rx_data[7:6] != 2'b00) begin
                  state_nxt = S_ERR;
               end else begin
                  len_nxt[13:8] = bus.rx_data[5:0];
                  state_nxt     = S_LEN_LO;
               end
            end
         end
         S_LEN_LO: begin
            if (fire) begin
               len_nxt[7:0] = bus.rx_data;
               addr_nxt     = '0;
               if ({len[13:8], bus.rx_data} == 14'd0) begin
                  state_nxt = S_PAYLOAD_END;
               end else begin
                  state_nxt = S_DATA_HI;
               end
            end
         end
         S_DATA_HI: begin
            if (fire) begin
               // Raw image byte order: first byte lands in the upper half
               data_nxt[15:8] = bus.rx_data;
`ifdef FLASH_LOADER_CHECKSUM_EN
               csum_nxt       = csum ^ bus.rx_data;
`endif
               state_nxt      = S_DATA_LO;
            end
         end
         S_DATA_LO: begin
            if (fire) begin
               data_nxt[7:0] = bus.rx_data;
`ifdef FLASH_LOADER_CHECKSUM_EN
               csum_nxt      = csum ^ bus.rx_data;
`endif
               state_nxt     = S_WRITE;
            end
         end
         S_WRITE: begin
            // addr/data are held through this cycle; advance only afterwards
            addr_nxt = addr + 14'd1;
            if ((addr + 14'd1) == len) begin
               state_nxt = S_PAYLOAD_END;
            end else begin
               state_nxt = S_DATA_HI;
            end
         end
`ifdef FLASH_LOADER_CHECKSUM_EN
         S_CSUM: begin
            if (fire) begin
               state_nxt = (bus.rx_data == csum) ? S_DONE : S_ERR;
            end
         end
`endif
         default: begin
            state_nxt = S_IDLE;
         end
      endcase
   end

   // State and datapath registers; reset aborts any frame and wins over a same-cycle byte
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= S_IDLE;
         len   <= '0;
         addr  <= '0;
         data  <= '0;
`ifdef FLASH_LOADER_CHECKSUM_EN
         csum  <= '0;
`endif
      end else begin
         state <= state_nxt;
         len   <= len_nxt;
         addr  <= addr_nxt;
         data  <= data_nxt;
`ifdef FLASH_LOADER_CHECKSUM_EN
         csum  <= csum_nxt;
`endif
      end
   end

endmodule

// File: tb/tb_flash_loader.sv
// Self-checking bench for flash_loader: randomized frames against a frame-level reference model.
// Latency: n/a (testbench).
// Backpressure: driver holds each byte until it observes rx_ready, optionally with idle gaps.
module tb_flash_loader;

`ifdef FLASH_LOADER_CHECKSUM_EN
   localparam int CS = 1;
`else
   localparam int CS = 0;
`endif

   logic clk = 1'b0;
   logic rst;

   flash_loader_if bus ();

   flash_loader dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;
   int cyc   = 0;

   logic [7:0]  tx_q[$];
   logic [29:0] exp_q[$];
   logic [29:0] got_q[$];
   bit          exp_done;
   int          ready_lo;
   int          wr_viol;
   bit          hold_seen;

   always @(posedge clk) cyc <= cyc + 1;

   // Passive monitor, sampled mid-cycle
   always @(negedge clk) begin
      if (!rst) begin
         if (bus.flash_wren) got_q.push_back({bus.flash_addr, bus.flash_data});
         if (bus.flash_wren == bus.rx_ready) wr_viol++;
         if (!bus.rx_ready) ready_lo++;
         if (bus.core_hold) hold_seen = 1'b1;
      end
   end

   // Reference model: expected frame bytes, expected writes and outcome from the frame definition
   function automatic void build_frame(input int len, input bit bad, input bit force55);
      logic [7:0] pay[$];
      logic [7:0] x;
      logic [7:0] b;
      x = 8'h00;
      tx_q  = {};
      exp_q = {};
      tx_q.push_back(8'h55);
      tx_q.push_back(8'(len >> 8));
      tx_q.push_back(8'(len));
      for (int i = 0; i < 2 * len; i++) begin
         b = force55 ? 8'h55 : 8'($urandom);
         pay.push_back(b);
         tx_q.push_back(b);
         x = x ^ b;
      end
      for (int i = 0; i < len; i++) exp_q.push_back({14'(i), pay[2*i], pay[2*i+1]});
      if (CS == 1) tx_q.push_back(bad ? (x ^ 8'($urandom_range(1, 255))) : x);
      exp_done = !bad;
   endfunction

   task automatic send_byte(input logic [7:0] b, input bit gaps);
      int budget;
      if (gaps) begin
         bus.rx_valid = 1'b0;
         bus.rx_data  = 8'($urandom);
         repeat ($urandom_range(0, 2)) @(negedge clk);
      end
      bus.rx_valid = 1'b1;
      bus.rx_data  = b;
      budget = 20;
      while (!bus.rx_ready && budget > 0) begin
         @(negedge clk);
         budget--;
      end
      if (budget == 0) begin
         n_cmp++; n_bad++;
         $display("FAIL send_byte_timeout byte=%h rx_ready=%b required=1", b, bus.rx_ready);
      end
      @(negedge clk);
   endtask

   task automatic send_frame(input bit gaps);
      foreach (tx_q[i]) send_byte(tx_q[i], gaps);
      bus.rx_valid = 1'b0;
   endtask

   task automatic wait_end(output int t);
      int budget;
      budget = 40;
      while (!(bus.done || bus.error) && budget > 0) begin
         @(negedge clk);
         budget--;
      end
      t = cyc;
      if (budget == 0) begin
         n_cmp++; n_bad++;
         $display("FAIL wait_end_timeout done=%b error=%b required=one_set", bus.done, bus.error);
      end
      repeat (3) @(negedge clk);
   endtask

   task automatic test_reset;
      rst = 1'b1;
      bus.rx_valid = 1'b0;
      bus.rx_data  = 8'h55;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      n_cmp++; if (bus.rx_ready !== 1'b1) begin n_bad++; $display("FAIL reset_rx_ready got=%b exp=1", bus.rx_ready); end
      n_cmp++; if (bus.flash_wren !== 1'b0) begin n_bad++; $display("FAIL reset_wren got=%b exp=0", bus.flash_wren); end
      n_cmp++; if (bus.flash_addr !== 14'd0) begin n_bad++; $display("FAIL reset_addr got=%h exp=0", bus.flash_addr); end
      n_cmp++; if (bus.flash_data !== 16'd0) begin n_bad++; $display("FAIL reset_data got=%h exp=0", bus.flash_data); end
      n_cmp++; if (bus.done !== 1'b0) begin n_bad++; $display("FAIL reset_done got=%b exp=0", bus.done); end
      n_cmp++; if (bus.error !== 1'b0) begin n_bad++; $display("FAIL reset_error got=%b exp=0", bus.error); end
      n_cmp++; if (bus.core_hold !== 1'b0) begin n_bad++; $display("FAIL reset_hold got=%b exp=0", bus.core_hold); end
   endtask

   task automatic test_known_load;
      int t;
      tx_q  = '{8'h55, 8'h00, 8'h02, 8'h0C, 8'h94, 8'h34, 8'h00};
      if (CS == 1) tx_q.push_back(8'hAC);
      exp_q = '{{14'd0, 16'h0C94}, {14'd1, 16'h3400}};
      got_q = {};
      hold_seen = 1'b0;
      send_frame(1'b0);
      wait_end(t);
      n_cmp++; if (got_q.size() != 2) begin n_bad++; $display("FAIL known_nwrites got=%0d exp=2", got_q.size()); end
      foreach (exp_q[i]) begin
         n_cmp++;
         if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin n_bad++; $display("FAIL known_write%0d got=%h exp=%h", i, got_q[i], exp_q[i]); end
      end
      n_cmp++; if (bus.done !== 1'b1) begin n_bad++; $display("FAIL known_done got=%b exp=1", bus.done); end
      n_cmp++; if (bus.error !== 1'b0) begin n_bad++; $display("FAIL known_error got=%b exp=0", bus.error); end
      n_cmp++; if (bus.core_hold !== 1'b0) begin n_bad++; $display("FAIL known_hold_end got=%b exp=0", bus.core_hold); end
      n_cmp++; if (hold_seen !== 1'b1) begin n_bad++; $display("FAIL known_hold_during got=%b exp=1", hold_seen); end
   endtask

`ifdef FLASH_LOADER_CHECKSUM_EN
   task automatic test_bad_csum;
      int t;
      tx_q  = '{8'h55, 8'h00, 8'h02, 8'h0C, 8'h94, 8'h34, 8'h00, 8'h00};
      exp_q = '{{14'd0, 16'h0C94}, {14'd1, 16'h3400}};
      got_q = {};
      send_frame(1'b1);
      wait_end(t);
      n_cmp++; if (got_q.size() != 2) begin n_bad++; $display("FAIL badcs_nwrites got=%0d exp=2", got_q.size()); end
      n_cmp++; if (bus.error !== 1'b1) begin n_bad++; $display("FAIL badcs_error got=%b exp=1", bus.error); end
      n_cmp++; if (bus.done !== 1'b0) begin n_bad++; $display("FAIL badcs_done got=%b exp=0", bus.done); end
      n_cmp++; if (bus.core_hold !== 1'b1) begin n_bad++; $display("FAIL badcs_hold got=%b exp=1", bus.core_hold); end
   endtask
`endif

   task automatic test_length_bound;
      int t;
      for (int k = 0; k < 3; k++) begin
         tx_q  = '{8'h55};
         tx_q.push_back(8'($urandom_range(8'h40, 8'hFF)));
         got_q = {};
         send_frame(1'b1);
         wait_end(t);
         n_cmp++; if (bus.error !== 1'b1) begin n_bad++; $display("FAIL lenbound_error k=%0d got=%b exp=1", k, bus.error); end
         n_cmp++; if (bus.done !== 1'b0) begin n_bad++; $display("FAIL lenbound_done k=%0d got=%b exp=0", k, bus.done); end
         n_cmp++; if (bus.core_hold !== 1'b1) begin n_bad++; $display("FAIL lenbound_hold k=%0d got=%b exp=1", k, bus.core_hold); end
         n_cmp++; if (got_q.size() != 0) begin n_bad++; $display("FAIL lenbound_nwrites k=%0d got=%0d exp=0", k, got_q.size()); end
      end
   endtask

   task automatic test_zero_length;
      int t;
      build_frame(0, 1'b0, 1'b0);
      got_q = {};
      send_frame(1'b0);
      wait_end(t);
      n_cmp++; if (bus.done !== 1'b1) begin n_bad++; $display("FAIL zero_done got=%b exp=1", bus.done); end
      n_cmp++; if (bus.core_hold !== 1'b0) begin n_bad++; $display("FAIL zero_hold got=%b exp=0", bus.core_hold); end
      n_cmp++; if (got_q.size() != 0) begin n_bad++; $display("FAIL zero_nwrites got=%0d exp=0", got_q.size()); end
   endtask

   task automatic test_random_frames;
      int t;
      bit bad;
      for (int f = 0; f < 6; f++) begin
         bad = (CS == 1) && ($urandom_range(0, 2) == 0);
         build_frame($urandom_range(1, 6), bad, f == 0);
         got_q = {};
         send_frame(1'b1);
         wait_end(t);
         n_cmp++; if (got_q.size() != exp_q.size()) begin n_bad++; $display("FAIL rand%0d_nwrites got=%0d exp=%0d", f, got_q.size(), exp_q.size()); end
         foreach (exp_q[i]) begin
            n_cmp++;
            if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin n_bad++; $display("FAIL rand%0d_write%0d got=%h exp=%h", f, i, got_q[i], exp_q[i]); end
         end
         n_cmp++; if (bus.done !== exp_done) begin n_bad++; $display("FAIL rand%0d_done got=%b exp=%b", f, bus.done, exp_done); end
         n_cmp++; if (bus.error !== !exp_done) begin n_bad++; $display("FAIL rand%0d_error got=%b exp=%b", f, bus.error, !exp_done); end
      end
   endtask

   task automatic test_back_to_back;
      int t0, t1;
      build_frame(4, 1'b0, 1'b0);
      got_q = {};
      ready_lo = 0;
      wr_viol = 0;
      t0 = cyc;
      send_frame(1'b0);
      wait_end(t1);
      n_cmp++; if ((t1 - t0) != 3 + 3 * 4 + CS) begin n_bad++; $display("FAIL b2b_cycles got=%0d exp=%0d", t1 - t0, 3 + 3 * 4 + CS); end
      n_cmp++; if (ready_lo != 4) begin n_bad++; $display("FAIL b2b_ready_low got=%0d exp=4", ready_lo); end
      n_cmp++; if (wr_viol != 0) begin n_bad++; $display("FAIL b2b_ready_vs_wren got=%0d exp=0", wr_viol); end
      n_cmp++; if (got_q.size() != exp_q.size()) begin n_bad++; $display("FAIL b2b_nwrites got=%0d exp=%0d", got_q.size(), exp_q.size()); end
      foreach (exp_q[i]) begin
         n_cmp++;
         if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin n_bad++; $display("FAIL b2b_write%0d got=%h exp=%h", i, got_q[i], exp_q[i]); end
      end
      n_cmp++; if (bus.done !== 1'b1) begin n_bad++; $display("FAIL b2b_done got=%b exp=1", bus.done); end
   endtask

   task automatic test_mid_reset;
      int t;
      logic [7:0] junk;
      build_frame(2, 1'b0, 1'b0);
      for (int i = 0; i < 4; i++) send_byte(tx_q[i], 1'b0);
      // Reset with a sync byte on the bus: it must be dropped
      rst = 1'b1;
      bus.rx_valid = 1'b1;
      bus.rx_data  = 8'h55;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      bus.rx_valid = 1'b0;
      @(negedge clk);
      n_cmp++; if (bus.rx_ready !== 1'b1) begin n_bad++; $display("FAIL midrst_rx_ready got=%b exp=1", bus.rx_ready); end
      n_cmp++; if (bus.flash_data !== 16'd0) begin n_bad++; $display("FAIL midrst_data got=%h exp=0", bus.flash_data); end
      n_cmp++; if (bus.flash_addr !== 14'd0) begin n_bad++; $display("FAIL midrst_addr got=%h exp=0", bus.flash_addr); end
      n_cmp++; if (bus.core_hold !== 1'b0) begin n_bad++; $display("FAIL midrst_hold got=%b exp=0", bus.core_hold); end
      n_cmp++; if (bus.done !== 1'b0 || bus.error !== 1'b0) begin n_bad++; $display("FAIL midrst_status got=%b%b exp=00", bus.done, bus.error); end
      for (int k = 0; k < 3; k++) begin
         junk = 8'($urandom);
         if (junk == 8'h55) junk = 8'hAA;
         send_byte(junk, 1'b1);
      end
      bus.rx_valid = 1'b0;
      @(negedge clk);
      n_cmp++; if (bus.core_hold !== 1'b0) begin n_bad++; $display("FAIL midrst_junk_hold got=%b exp=0", bus.core_hold); end
      build_frame(3, 1'b0, 1'b0);
      got_q = {};
      send_frame(1'b1);
      wait_end(t);
      n_cmp++; if (got_q.size() != exp_q.size()) begin n_bad++; $display("FAIL midrst_nwrites got=%0d exp=%0d", got_q.size(), exp_q.size()); end
      foreach (exp_q[i]) begin
         n_cmp++;
         if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin n_bad++; $display("FAIL midrst_write%0d got=%h exp=%h", i, got_q[i], exp_q[i]); end
      end
      n_cmp++; if (bus.done !== 1'b1) begin n_bad++; $display("FAIL midrst_done got=%b exp=1", bus.done); end
   endtask

   task automatic test_reset_in_write;
      int extra;
      build_frame(3, 1'b0, 1'b0);
      for (int i = 0; i < 5; i++) send_byte(tx_q[i], 1'b0);
      n_cmp++; if (bus.flash_wren !== 1'b1) begin n_bad++; $display("FAIL rstwr_in_write got=%b exp=1", bus.flash_wren); end
      rst = 1'b1;
      bus.rx_valid = 1'b0;
      @(negedge clk);
      n_cmp++; if (bus.flash_wren !== 1'b0) begin n_bad++; $display("FAIL rstwr_wren_after got=%b exp=0", bus.flash_wren); end
      rst = 1'b0;
      extra = 0;
      repeat (10) begin
         @(negedge clk);
         if (bus.flash_wren) extra++;
      end
      n_cmp++; if (extra != 0) begin n_bad++; $display("FAIL rstwr_late_writes got=%0d exp=0", extra); end
      n_cmp++; if (bus.core_hold !== 1'b0) begin n_bad++; $display("FAIL rstwr_hold got=%b exp=0", bus.core_hold); end
   endtask

   initial begin
      rst = 1'b1;
      bus.rx_valid = 1'b0;
      bus.rx_data  = 8'h00;
      @(negedge clk);
      test_reset();
      test_known_load();
`ifdef FLASH_LOADER_CHECKSUM_EN
      test_bad_csum();
`endif
      test_length_bound();
      test_zero_length();
      test_random_frames();
      test_back_to_back();
      test_mid_reset();
      test_reset_in_write();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog expired cycles=%0d required=finish", cyc);
      $fatal(1);
   end

endmodule
